// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the instruction loader.
// Provides the FSM state enum and instruction byte-lane constants.
`ifndef WORD
`define WORD 32
`endif
`ifndef INST_SIZE
`define INST_SIZE 32
`endif

package loader_pkg;

  localparam int INST_W         = `INST_SIZE;
  localparam int BYTES_PER_INST = `INST_SIZE / 8;
  localparam int LANE_W         = $clog2(BYTES_PER_INST);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/inst_byte_packer.sv
// inst_byte_packer: places stream bytes into little-endian lanes.
// Ports: clr_i/load_i/data_i in; word_o assembled word, full_o last lane.
module inst_byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [7:0]        data_i,
  output logic [INST_W-1:0] word_o,
  output logic              full_o
);

  logic [LANE_W-1:0] lane_q;
  logic [INST_W-1:0] word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
      word_q <= '0;
    end else if (clr_i) begin
      lane_q <= '0;
      word_q <= '0;
    end else if (load_i) begin
      word_q[{lane_q, 3'b000} +: 8] <= data_i;
      lane_q <= lane_q + 1'b1;
    end
  end

  // High while the next accepted byte completes the word.
  assign full_o = (lane_q == LANE_W'(BYTES_PER_INST - 1));
  assign word_o = word_q;

endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: packs a byte stream into words and writes imem.
// Ports: start/len/abort control, s_* stream, mem_* write, status, cpu_hold.
`ifndef WORD
`define WORD 32
`endif
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              abort,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mem_we,
  output logic [`WORD-1:0]  mem_addr,
  output logic [INST_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  localparam int IW = $clog2(DEPTH);

  state_t           state_q;
  logic [CNT_W-1:0] len_q;
  logic [IW-1:0]    idx_q;
  logic             load_ok_q;
  logic             err_q;

  logic              hs;
  logic              clr;
  logic              full;
  logic              last;
  logic [INST_W-1:0] word;

  // abort wins over any same-cycle handshake or write.
  assign s_ready = (state_q == RECV) & ~abort;
  assign mem_we  = (state_q == WRITE) & ~abort;
  assign hs      = s_valid & s_ready;
  assign clr     = (state_q == IDLE) & start & ~abort;
  assign last    = ({1'b0, idx_q} == len_q - 1'b1);

  inst_byte_packer u_packer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .load_i (hs),
    .data_i (s_data),
    .word_o (word),
    .full_o (full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      load_ok_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (clr) begin
            idx_q <= '0;
            if (len == '0) begin
              state_q <= DONE;
            end else begin
              len_q   <= (len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : len;
              state_q <= RECV;
            end
          end
        end
        RECV: begin
          if (abort) begin
            state_q   <= IDLE;
            err_q     <= 1'b1;
            load_ok_q <= 1'b0;
          end else if (hs & full) begin
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (abort) begin
            state_q   <= IDLE;
            err_q     <= 1'b1;
            load_ok_q <= 1'b0;
          end else if (last) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= RECV;
          end
        end
        DONE: begin
          load_ok_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr  = {{(`WORD - IW - 2){1'b0}}, idx_q, 2'b00};
  assign mem_wdata = word;
  assign busy      = (state_q == RECV) | (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign cpu_hold  = ~((state_q == IDLE) & load_ok_q);

endmodule
